elastic_stream_buffer: RTL and testbench
========================================

ELASTIC_STREAM_BUFFER -- requirements
Module: elastic_stream_buffer

Interface
REQ-001 Parameter D_WIDTH, default 8: data bits per beat.
REQ-002 Parameter U_WIDTH, default 1: tuser bits per beat.
REQ-003 Parameter DEPTH, default 4: storage entries; legal range 2..64, power of two.
REQ-004 Parameter OUT_MODE, default BYPASS: BYPASS = zero-latency fall-through when empty; REGOUT = all down_* driven from flops.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 flush  in  1  synchronous discard of all stored beats.
REQ-009 up_data  in  D_WIDTH  upstream data.
REQ-010 up_valid  in  1  upstream beat valid.
REQ-011 up_tlast  in  1  end-of-line/frame marker.
REQ-012 up_tuser  in  U_WIDTH  sideband (start-of-frame etc.).
REQ-013 up_ready  out  1  accept; driven directly from a flop, no combinational path.
REQ-014 down_data  out  D_WIDTH  downstream data.
REQ-015 down_valid  out  1  downstream beat valid.
REQ-016 down_tlast  out  1  marker, travels with its beat.
REQ-017 down_tuser  out  U_WIDTH  sideband, travels with its beat.
REQ-018 down_ready  in  1  downstream accept.
REQ-019 level  out  $clog2(DEPTH)+1  beats held (including REGOUT output register).

Function
REQ-020 Push = up_valid & up_ready; pop = down_valid & down_ready; beats SHALL leave in arrival order with data/tlast/tuser unaltered.
REQ-021 up_ready SHALL be a flop loaded each cycle with (level_next < DEPTH), level_next being post-push/pop/flush occupancy.
REQ-022 BYPASS, level==0: down_* SHALL equal up_* combinationally; if down_ready=1 beat passes with no storage and level stays 0; if down_ready=0 beat is stored.
REQ-023 BYPASS, level>0: down_* SHALL come from oldest stored entry; up_* never bypasses stored beats.
REQ-024 REGOUT: down_valid and down_* SHALL be flop outputs; push-to-down_valid latency 1 cycle; head refilled from storage or input in the pop cycle, sustaining 1 beat/cycle.
REQ-025 Simultaneous push and pop at 0<level<DEPTH: level unchanged.
REQ-026 Full (level==DEPTH): up_ready=0 the following cycle; a pop while full SHALL raise up_ready next cycle.
REQ-027 up_valid with up_ready=0: no state change; upstream holds beat.
REQ-028 down_valid, once asserted, SHALL hold with stable down_* until pop (no retraction).
REQ-029 flush=1: level_next=0, stored beats discarded, any push that cycle discarded, down_valid=0 next cycle, up_ready=1 next cycle; flush overrides push/pop.
REQ-030 Pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH nor underflow.

Reset
REQ-031 rst asserted: level=0, pointers=0, down_valid=0, up_ready=0, REGOUT head invalid, immediately (async).
REQ-032 First clock edge after rst deassert: up_ready=1.
REQ-033 Storage contents SHALL not be reset; down_data/tlast/tuser undefined while down_valid=0.
REQ-034 rst mid-transfer SHALL drop all beats; no partial beat emerges afterwards.

Structure
REQ-035 Package stream_buf_pkg SHALL hold the OUT_MODE enum (BYPASS, REGOUT) and the DEPTH legality check constant.
REQ-036 Storage SHALL be sub-module stream_buf_regfile (DEPTH x (D_WIDTH+U_WIDTH+1), one write port, one async read port, no reset).
REQ-037 Elaboration SHALL fail for DEPTH outside 2..64 or non-power-of-two.

Verification
REQ-038 BYPASS, DEPTH=4, down_ready=1, beats 0x11,0x22,0x33 back-to-back -> same-cycle on down_data, level stays 0.
REQ-039 BYPASS, down_ready=0, push 5 beats 0xA0..0xA4 -> 4 accepted, up_ready=0 cycle after 4th, level=4; down_ready=1 -> 0xA0..0xA3 in order, up_ready=1 one cycle after first pop.
REQ-040 REGOUT, down_ready=1 continuous, 16 beats tlast on 16th -> each appears 1 cycle later, tlast only on 16th, no bubbles.
REQ-041 level=3, flush with up_valid=1 (0x55) -> next cycle level=0, down_valid=0, 0x55 never emitted.
REQ-042 level=2, async rst mid-cycle -> down_valid=0 and level=0 immediately, up_ready=1 first edge after release.
REQ-043 Random up_valid/down_ready 10k beats both modes -> scoreboard order match, no down_valid retraction, level == pushes-pops.

Source files
------------

// File: rtl/stream_buf_pkg.sv
// Shared types and elaboration-time checks for the elastic stream buffer.
// Anything that instantiates the buffer imports this package to pick an output mode.
package stream_buf_pkg;

  typedef enum logic {
    BYPASS = 1'b0,
    REGOUT = 1'b1
  } out_mode_e;

  localparam int MIN_DEPTH = 2;
  localparam int MAX_DEPTH = 64;

  // Power-of-two depth lets the read/write pointers wrap for free.
  function automatic bit depth_is_legal(input int depth);
    return (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/stream_buf_regfile.sv
// Beat storage for the elastic stream buffer: one write port, one asynchronous read port.
// The contents are deliberately left unreset; occupancy tracking lives in the parent.
module stream_buf_regfile #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/elastic_stream_buffer.sv
// Elastic FIFO for a valid/ready stream carrying data, tlast and tuser per beat.
// BYPASS falls through combinationally when empty; REGOUT drives every down_* from flops.
module elastic_stream_buffer
  import stream_buf_pkg::*;
#(
  parameter int        D_WIDTH  = 8,
  parameter int        U_WIDTH  = 1,
  parameter int        DEPTH    = 4,
  parameter out_mode_e OUT_MODE = BYPASS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [D_WIDTH-1:0]       up_data,
  input  logic                     up_valid,
  input  logic                     up_tlast,
  input  logic [U_WIDTH-1:0]       up_tuser,
  output logic                     up_ready,
  output logic [D_WIDTH-1:0]       down_data,
  output logic                     down_valid,
  output logic                     down_tlast,
  output logic [U_WIDTH-1:0]       down_tuser,
  input  logic                     down_ready,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = D_WIDTH + U_WIDTH + 1;

  if (!depth_is_legal(DEPTH)) begin : g_depth_check
    $error("elastic_stream_buffer: DEPTH=%0d must be a power of two in 2..64", DEPTH);
  end

  logic          push;
  logic          pop;
  logic          wr_en;
  logic          rd_en;
  logic          fifo_empty;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] fifo_cnt;
  logic [LW-1:0] level_next;
  logic [EW-1:0] up_word;
  logic [EW-1:0] rd_word;

  assign push       = up_valid & up_ready;
  assign up_word    = {up_tuser, up_tlast, up_data};
  assign fifo_empty = (fifo_cnt == '0);

  stream_buf_regfile #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_regfile (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (up_word),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   fifo_cnt <= fifo_cnt + LW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - LW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Registered from next-cycle occupancy so upstream never sees a combinational path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_ready <= 1'b0;
    end else begin
      up_ready <= (level_next < LW'(DEPTH));
    end
  end

  if (OUT_MODE == BYPASS) begin : g_bypass

    // Empty buffer shows the upstream beat directly; otherwise the oldest stored beat.
    always_comb begin
      down_valid                          = 1'b1;
      {down_tuser, down_tlast, down_data} = rd_word;
      if (fifo_empty) begin
        down_valid                          = up_valid & up_ready & ~flush;
        {down_tuser, down_tlast, down_data} = up_word;
      end
    end

    assign pop   = down_valid & down_ready;
    assign wr_en = push & ~flush & ~(fifo_empty & down_ready);
    assign rd_en = pop & ~fifo_empty & ~flush;
    assign level = fifo_cnt;

    always_comb begin
      level_next = fifo_cnt;
      if (flush) begin
        level_next = '0;
      end else if (wr_en && !rd_en) begin
        level_next = fifo_cnt + LW'(1);
      end else if (rd_en && !wr_en) begin
        level_next = fifo_cnt - LW'(1);
      end
    end

  end else begin : g_regout

    logic          head_valid;
    logic [EW-1:0] head_word;
    logic          slot_free;
    logic          take_fifo;
    logic          take_up;

    // The head slot refills in the same cycle it empties, so the stream never bubbles.
    assign slot_free = ~head_valid | down_ready;
    assign take_fifo = slot_free & ~fifo_empty;
    assign take_up   = slot_free & fifo_empty & push;
    assign rd_en     = take_fifo & ~flush;
    assign wr_en     = push & ~take_up & ~flush;
    assign pop       = head_valid & down_ready;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        head_valid <= 1'b0;
      end else if (flush) begin
        head_valid <= 1'b0;
      end else if (slot_free) begin
        head_valid <= take_fifo | take_up;
      end
    end

    always_ff @(posedge clk) begin
      if (!flush && (take_fifo || take_up)) begin
        head_word <= take_fifo ? rd_word : up_word;
      end
    end

    assign down_valid                          = head_valid;
    assign {down_tuser, down_tlast, down_data} = head_word;
    assign level                               = fifo_cnt + LW'(head_valid);

    always_comb begin
      level_next = level;
      if (flush) begin
        level_next = '0;
      end else if (push && !pop) begin
        level_next = level + LW'(1);
      end else if (pop && !push) begin
        level_next = level - LW'(1);
      end
    end

  end

endmodule

// File: tb/tb_elastic_stream_buffer.sv
// Self-checking bench for elastic_stream_buffer in both output modes against a queue model.
// Both modes are instantiated side by side on shared inputs; 'mode' selects which one is observed.
module tb_elastic_stream_buffer;
  import stream_buf_pkg::*;

  localparam int DW    = 8;
  localparam int UW    = 2;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [UW-1:0] u;
    logic          t;
    logic [DW-1:0] d;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [DW-1:0] up_data = '0;
  logic          up_valid = 1'b0;
  logic          up_tlast = 1'b0;
  logic [UW-1:0] up_tuser = '0;
  logic          down_ready = 1'b0;

  logic          b_up_ready, r_up_ready, up_ready;
  logic [DW-1:0] b_down_data, r_down_data, down_data;
  logic          b_down_valid, r_down_valid, down_valid;
  logic          b_down_tlast, r_down_tlast, down_tlast;
  logic [UW-1:0] b_down_tuser, r_down_tuser, down_tuser;
  logic [LW-1:0] b_level, r_level, level;

  bit mode = 1'b0;

  elastic_stream_buffer #(.D_WIDTH(DW), .U_WIDTH(UW), .DEPTH(DEPTH), .OUT_MODE(BYPASS)) u_bypass (
    .clk(clk), .rst(rst), .flush(flush),
    .up_data(up_data), .up_valid(up_valid), .up_tlast(up_tlast), .up_tuser(up_tuser), .up_ready(b_up_ready),
    .down_data(b_down_data), .down_valid(b_down_valid), .down_tlast(b_down_tlast), .down_tuser(b_down_tuser),
    .down_ready(down_ready), .level(b_level)
  );

  elastic_stream_buffer #(.D_WIDTH(DW), .U_WIDTH(UW), .DEPTH(DEPTH), .OUT_MODE(REGOUT)) u_regout (
    .clk(clk), .rst(rst), .flush(flush),
    .up_data(up_data), .up_valid(up_valid), .up_tlast(up_tlast), .up_tuser(up_tuser), .up_ready(r_up_ready),
    .down_data(r_down_data), .down_valid(r_down_valid), .down_tlast(r_down_tlast), .down_tuser(r_down_tuser),
    .down_ready(down_ready), .level(r_level)
  );

  assign up_ready   = mode ? r_up_ready   : b_up_ready;
  assign down_data  = mode ? r_down_data  : b_down_data;
  assign down_valid = mode ? r_down_valid : b_down_valid;
  assign down_tlast = mode ? r_down_tlast : b_down_tlast;
  assign down_tuser = mode ? r_down_tuser : b_down_tuser;
  assign level      = mode ? r_level      : b_level;

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  beat_t q[$];
  bit    exp_up_ready = 1'b0;
  bit    exp_dv = 1'b0;
  beat_t exp_beat = '0;
  bit    prev_stall = 1'b0;
  beat_t prev_beat = '0;
  bit    last_push = 1'b0;
  int    beats_out = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s mode=%0d observed=0x%0h expected=0x%0h", tag, mode, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input bit v, input logic [DW-1:0] d, input bit t,
                                input logic [UW-1:0] u, input bit dr, input bit fl);
    up_valid   = v;
    up_data    = d;
    up_tlast   = t;
    up_tuser   = u;
    down_ready = dr;
    flush      = fl;
  endtask

  // Expected outputs: the oldest held beat if any, else (bypass only) the offered upstream beat.
  task automatic check_output();
    exp_dv   = 1'b0;
    exp_beat = '0;
    if (q.size() > 0) begin
      exp_dv   = 1'b1;
      exp_beat = q[0];
    end else if (!mode) begin
      exp_dv   = up_valid & exp_up_ready & ~flush;
      exp_beat = {up_tuser, up_tlast, up_data};
    end
    check("up_ready", 32'(up_ready), 32'(exp_up_ready));
    check("level", 32'(level), q.size());
    check("down_valid", 32'(down_valid), 32'(exp_dv));
    if (exp_dv) begin
      check("down_data", 32'(down_data), 32'(exp_beat.d));
      check("down_tlast", 32'(down_tlast), 32'(exp_beat.t));
      check("down_tuser", 32'(down_tuser), 32'(exp_beat.u));
    end
    if (prev_stall) begin
      check("hold_valid", 32'(down_valid), 32'd1);
      check("hold_beat", 32'({down_tuser, down_tlast, down_data}), 32'(prev_beat));
    end
  endtask

  task automatic update_model();
    bit push, pop, pass;
    push       = up_valid & exp_up_ready;
    pop        = exp_dv & down_ready;
    last_push  = push;
    prev_stall = exp_dv & ~down_ready & ~flush;
    prev_beat  = exp_beat;
    if (flush) begin
      q.delete();
    end else begin
      pass = pop && (q.size() == 0);
      if (pop) beats_out++;
      if (pop && !pass) void'(q.pop_front());
      if (push && !pass) q.push_back({up_tuser, up_tlast, up_data});
    end
    exp_up_ready = (q.size() < DEPTH);
  endtask

  task automatic step();
    #1;
    check_output();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    apply_stimulus(0, '0, 0, '0, 0, 0);
    q.delete();
    exp_up_ready = 1'b0;
    prev_stall   = 1'b0;
    @(negedge clk);
    #1;
    check("rst_level", 32'(level), 32'd0);
    check("rst_down_valid", 32'(down_valid), 32'd0);
    check("rst_up_ready", 32'(up_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    #1;
    check("release_up_ready", 32'(up_ready), 32'd1);
  endtask

  task automatic flush_test();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, 8'(8'h30 + i), 0, 2'(i), 0, 0);
      step();
    end
    apply_stimulus(1, 8'h55, 1, 2'd3, 0, 1);
    #1;
    check("flush_pre_level", 32'(level), 32'd3);
    step();
    apply_stimulus(0, '0, 0, '0, 1, 0);
    #1;
    check("flush_level", 32'(level), 32'd0);
    check("flush_down_valid", 32'(down_valid), 32'd0);
    check("flush_up_ready", 32'(up_ready), 32'd1);
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic async_reset_test();
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1, 8'(8'h60 + i), 0, '0, 0, 0);
      step();
    end
    apply_stimulus(0, '0, 0, '0, 0, 0);
    #1;
    check("arst_pre_level", 32'(level), 32'd2);
    #1;
    rst = 1'b1;
    #1;
    check("arst_down_valid", 32'(down_valid), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_up_ready", 32'(up_ready), 32'd0);
    q.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("arst_release_up_ready", 32'(up_ready), 32'd1);
    exp_up_ready = (q.size() < DEPTH);
    @(negedge clk);
    apply_stimulus(0, '0, 0, '0, 1, 0);
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic random_run();
    int cycles;
    reset_dut();
    beats_out = 0;
    cycles    = 0;
    last_push = 1'b1;
    while (beats_out < 10000 && cycles < 40000) begin
      if (!(up_valid && !last_push)) begin
        up_valid = ($urandom_range(0, 3) != 0);
        up_data  = 8'($urandom);
        up_tlast = 1'($urandom);
        up_tuser = 2'($urandom);
      end
      down_ready = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 299) == 0);
      step();
      cycles++;
    end
    check("random_beats_done", 32'(beats_out >= 10000), 32'd1);
  endtask

  initial begin
    logic [DW-1:0] seq_pass [3];
    seq_pass = '{8'h11, 8'h22, 8'h33};

    mode = 1'b0;
    reset_dut();

    foreach (seq_pass[i]) begin
      apply_stimulus(1, seq_pass[i], 0, 2'(i), 1, 0);
      #1;
      check("bp_pass_data", 32'(down_data), 32'(seq_pass[i]));
      check("bp_pass_valid", 32'(down_valid), 32'd1);
      check("bp_pass_level", 32'(level), 32'd0);
      step();
    end

    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1, 8'(8'hA0 + i), 0, '0, 0, 0);
      step();
    end
    #1;
    check("bp_full_up_ready", 32'(up_ready), 32'd0);
    check("bp_full_level", 32'(level), 32'd4);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(0, '0, 0, '0, 1, 0);
      #1;
      check("bp_drain_data", 32'(down_data), 32'(8'hA0 + i));
      if (i == 1) check("bp_ready_after_pop", 32'(up_ready), 32'd1);
      step();
    end
    #1;
    check("bp_drained_level", 32'(level), 32'd0);

    flush_test();
    async_reset_test();

    mode = 1'b1;
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1, 8'(i + 1), (i == 15), 2'(i), 1, 0);
      #1;
      if (i > 0) begin
        check("ro_stream_valid", 32'(down_valid), 32'd1);
        check("ro_stream_data", 32'(down_data), 32'(i));
        check("ro_stream_tlast", 32'(down_tlast), 32'd0);
      end else begin
        check("ro_first_valid", 32'(down_valid), 32'd0);
      end
      step();
    end
    apply_stimulus(0, '0, 0, '0, 1, 0);
    #1;
    check("ro_last_data", 32'(down_data), 32'd16);
    check("ro_last_tlast", 32'(down_tlast), 32'd1);
    step();
    step();

    flush_test();
    async_reset_test();

    mode = 1'b0;
    random_run();
    mode = 1'b1;
    random_run();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
